instr_decode_stage: RTL and testbench

Pipelined, parametrised instruction-decode stage for the 16-bit Harvard core. It sits between instruction fetch and the ALU/regfile stage, with valid/ready on both sides and a 2-entry skid buffer. Each output is a registered, fully decoded micro-op: register indices, immediate/address, ALU op, write enable and illegal flag. It also flags read-after-write (RAW) hazards against the previously issued micro-op.

---
 rtl/decode_pkg.sv | 103 ++++++++++
 rtl/uop_skid_buf.sv | 51 +++++
 rtl/instr_decode_stage.sv | 122 ++++++++++++
 tb/tb_instr_decode_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, ALU codes, micro-op struct and decode helpers shared by the decode stage.
//   OPC_*        6-bit opcodes (0x00-0x10 legal, anything above is illegal)
//   ALU_OP_*     4-bit ALU selects, ALU_OP_NONE for non-ALU and illegal ops
//   uop_t        fully decoded micro-op carried through the skid buffer
//   UOP_RST      micro-op value seen on the outputs after reset
//   decode_instr pure decode of a 32-bit instruction word (hazard bit left 0)
//   src_use      which source fields an opcode reads, {rsrc2, rsrc1}
package decode_pkg;
    localparam logic [5:0] OPC_LDI  = 6'h00;
    localparam logic [5:0] OPC_MOV  = 6'h01;
    localparam logic [5:0] OPC_LD   = 6'h02;
    localparam logic [5:0] OPC_ST   = 6'h03;
    localparam logic [5:0] OPC_ADD  = 6'h04;
    localparam logic [5:0] OPC_SUB  = 6'h05;
    localparam logic [5:0] OPC_NEG  = 6'h06;
    localparam logic [5:0] OPC_MUL  = 6'h07;
    localparam logic [5:0] OPC_AND  = 6'h08;
    localparam logic [5:0] OPC_OR   = 6'h09;
    localparam logic [5:0] OPC_XOR  = 6'h0A;
    localparam logic [5:0] OPC_NAND = 6'h0B;
    localparam logic [5:0] OPC_NOR  = 6'h0C;
    localparam logic [5:0] OPC_XNOR = 6'h0D;
    localparam logic [5:0] OPC_NOT  = 6'h0E;
    localparam logic [5:0] OPC_SHL  = 6'h0F;
    localparam logic [5:0] OPC_SHR  = 6'h10;

    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_NEG  = 4'd2;
    localparam logic [3:0] ALU_OP_MUL  = 4'd3;
    localparam logic [3:0] ALU_OP_AND  = 4'd4;
    localparam logic [3:0] ALU_OP_OR   = 4'd5;
    localparam logic [3:0] ALU_OP_XOR  = 4'd6;
    localparam logic [3:0] ALU_OP_NAND = 4'd7;
    localparam logic [3:0] ALU_OP_NOR  = 4'd8;
    localparam logic [3:0] ALU_OP_XNOR = 4'd9;
    localparam logic [3:0] ALU_OP_NOT  = 4'd10;
    localparam logic [3:0] ALU_OP_SHL  = 4'd11;
    localparam logic [3:0] ALU_OP_SHR  = 4'd12;
    localparam logic [3:0] ALU_OP_NONE = 4'd15;

    typedef struct packed {
        logic [5:0]  opc;
        logic [3:0]  alu_op;
        logic [4:0]  rdst;
        logic [4:0]  rdst2;
        logic [4:0]  rsrc1;
        logic [4:0]  rsrc2;
        logic [15:0] imm;
        logic [7:0]  addr;
        logic        we;
        logic        mem_rd;
        logic        mem_wr;
        logic        illegal;
        logic        raw_hazard;
    } uop_t;

    localparam uop_t UOP_RST = '{alu_op: ALU_OP_NONE, default: '0};

    function automatic uop_t decode_instr(input logic [31:0] i);
        uop_t u;
        logic [5:0] o;
        o = i[31:26];
        u = '0;
        u.opc = o;
        u.alu_op = ALU_OP_NONE;
        if (o == OPC_LDI) begin
            u.rdst = i[25:21];
            u.imm  = i[15:0];
            u.we   = 1'b1;
        end else if (o == OPC_MOV) begin
            u.rdst  = i[25:21];
            u.rsrc2 = i[4:0];
            u.we    = 1'b1;
        end else if (o == OPC_LD) begin
            u.rdst   = i[25:21];
            u.addr   = i[7:0];
            u.mem_rd = 1'b1;
            u.we     = 1'b1;
        end else if (o == OPC_ST) begin
            u.addr   = i[25:18];
            u.rsrc2  = i[4:0];
            u.mem_wr = 1'b1;
        end else if (o <= OPC_SHR) begin
            // ALU opcodes are contiguous, so the select is the offset from ADD
            u.alu_op = 4'(o - OPC_ADD);
            u.rdst2  = i[25:21];
            u.rdst   = i[20:16];
            u.rsrc2  = i[9:5];
            u.rsrc1  = i[4:0];
            u.we     = 1'b1;
        end else begin
            u.illegal = 1'b1;
        end
        return u;
    endfunction

    function automatic logic [1:0] src_use(input logic [5:0] o);
        return (o == OPC_MOV || o == OPC_ST)            ? 2'b10 :
               (o == OPC_NEG || o == OPC_NOT)           ? 2'b01 :
               (o >= OPC_ADD && o <= OPC_SHR)           ? 2'b11 : 2'b00;
    endfunction
endpackage

// File: rtl/uop_skid_buf.sv
// uop_skid_buf: 2-entry valid/ready buffer (output register + skid register).
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_ready comes straight from a flop
//   in_data [W]           payload accepted on in_valid && in_ready
//   out_valid/out_ready   downstream handshake
//   out_data [W]          output register, held while out_valid && !out_ready
//   RST                   value loaded into both data registers on reset
module uop_skid_buf #(
    parameter int W = 8,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         acc;
    logic         drain;

    assign in_ready = !skid_valid;
    assign acc      = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    // Skid only fills when the output is stalled; it always promotes before new input is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= RST;
            skid_valid <= 1'b0;
            skid_data  <= RST;
        end else if (skid_valid) begin
            if (drain) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (!out_valid || drain) begin
            out_valid <= acc;
            if (acc)
                out_data <= in_data;
        end else if (acc) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end
endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: pipelined decode with 2-entry skid buffer and RAW hazard flag.
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready/in_instr   fetch side handshake and raw instruction
//   out_valid/out_ready      execute side handshake
//   out_opc .. out_illegal   registered decoded micro-op fields
//   out_raw_hazard           a used source matches the previous op's written register
//   DECODE_STATS_EN          when defined adds saturating stat_issued/stat_illegal/stat_hazard
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 5,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         out_opc,
    output logic [3:0]         out_alu_op,
    output logic [REG_AW-1:0]  out_rdst,
    output logic [REG_AW-1:0]  out_rdst2,
    output logic [REG_AW-1:0]  out_rsrc1,
    output logic [REG_AW-1:0]  out_rsrc2,
    output logic [DATA_W-1:0]  out_imm,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               out_we,
    output logic               out_mem_rd,
    output logic               out_mem_wr,
    output logic               out_illegal,
    output logic               out_raw_hazard
`ifdef DECODE_STATS_EN
   ,output logic [15:0]        stat_issued,
    output logic [15:0]        stat_illegal,
    output logic [15:0]        stat_hazard
`endif
);
    uop_t       dec;
    uop_t       dec_h;
    uop_t       cur;
    logic [31:0] iw;
    logic [1:0] use_src;
    logic       prev_we;
    logic [4:0] prev_rd;
    logic       hz;
    logic       hist_we;
    logic [4:0] hist_rdst;
    logic       xfer;

    assign iw      = {in_instr[INSTR_W-1 -: 6], in_instr[25:0]};
    assign dec     = decode_instr(iw);
    assign use_src = src_use(dec.opc);
    assign xfer    = out_valid && out_ready;

    // The op immediately ahead in program order is the one in the output register
    // when it is occupied (it transfers first), otherwise the last transferred op.
    assign prev_we = out_valid ? cur.we   : hist_we;
    assign prev_rd = out_valid ? cur.rdst : hist_rdst;
    assign hz      = prev_we && ((use_src[0] && dec.rsrc1 == prev_rd) ||
                                 (use_src[1] && dec.rsrc2 == prev_rd));

    always_comb begin
        dec_h = dec;
        dec_h.raw_hazard = hz;
    end

    uop_skid_buf #(
        .W   ($bits(uop_t)),
        .RST (UOP_RST)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec_h),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (cur)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_we   <= 1'b0;
            hist_rdst <= '0;
        end else if (xfer) begin
            hist_we   <= cur.we;
            hist_rdst <= cur.rdst;
        end
    end

    assign out_opc        = cur.opc;
    assign out_alu_op     = cur.alu_op;
    assign out_rdst       = REG_AW'(cur.rdst);
    assign out_rdst2      = REG_AW'(cur.rdst2);
    assign out_rsrc1      = REG_AW'(cur.rsrc1);
    assign out_rsrc2      = REG_AW'(cur.rsrc2);
    assign out_imm        = DATA_W'(cur.imm);
    assign out_addr       = ADDR_W'(cur.addr);
    assign out_we         = cur.we;
    assign out_mem_rd     = cur.mem_rd;
    assign out_mem_wr     = cur.mem_wr;
    assign out_illegal    = cur.illegal;
    assign out_raw_hazard = cur.raw_hazard;

`ifdef DECODE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued  <= '0;
            stat_illegal <= '0;
            stat_hazard  <= '0;
        end else if (xfer) begin
            stat_issued  <= stat_issued + 16'(stat_issued != 16'hFFFF);
            stat_illegal <= stat_illegal + 16'(cur.illegal && stat_illegal != 16'hFFFF);
            stat_hazard  <= stat_hazard + 16'(cur.raw_hazard && stat_hazard != 16'hFFFF);
        end
    end
`endif
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed stimulus with a scoreboard of expected micro-ops.
module tb_instr_decode_stage;
    typedef struct packed {
        logic [5:0]  opc;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rd2;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [15:0] imm;
        logic [7:0]  addr;
        logic        we;
        logic        mr;
        logic        mw;
        logic        ill;
        logic        hz;
    } exp_t;

    logic        clk = 0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opc;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_rdst, out_rdst2, out_rsrc1, out_rsrc2;
    logic [15:0] out_imm;
    logic [7:0]  out_addr;
    logic        out_we, out_mem_rd, out_mem_wr, out_illegal, out_raw_hazard;
`ifdef DECODE_STATS_EN
    logic [15:0] stat_issued, stat_illegal, stat_hazard;
`endif
    logic [58:0] act;

    int   checks = 0;
    int   fails = 0;
    exp_t q[$];
    exp_t ce;
    logic cpwe;
    logic [4:0] cprd;
    int   ex_issued, ex_illegal, ex_hazard;

    always #5 clk = ~clk;

    instr_decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_opc(out_opc), .out_alu_op(out_alu_op),
        .out_rdst(out_rdst), .out_rdst2(out_rdst2), .out_rsrc1(out_rsrc1), .out_rsrc2(out_rsrc2),
        .out_imm(out_imm), .out_addr(out_addr), .out_we(out_we), .out_mem_rd(out_mem_rd),
        .out_mem_wr(out_mem_wr), .out_illegal(out_illegal), .out_raw_hazard(out_raw_hazard)
`ifdef DECODE_STATS_EN
       ,.stat_issued(stat_issued), .stat_illegal(stat_illegal), .stat_hazard(stat_hazard)
`endif
    );

    assign act = {out_opc, out_alu_op, out_rdst, out_rdst2, out_rsrc1, out_rsrc2,
                  out_imm, out_addr, out_we, out_mem_rd, out_mem_wr, out_illegal, out_raw_hazard};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] w, input logic pwe, input logic [4:0] prd);
        exp_t e;
        logic [5:0] o;
        logic u1, u2;
        e = '0;
        o = w[31:26];
        u1 = 0;
        u2 = 0;
        e.opc = o;
        e.alu = 4'hF;
        case (o)
            6'h00: begin e.rd = w[25:21]; e.imm = w[15:0]; e.we = 1; end
            6'h01: begin e.rd = w[25:21]; e.s2 = w[4:0]; e.we = 1; u2 = 1; end
            6'h02: begin e.rd = w[25:21]; e.addr = w[7:0]; e.mr = 1; e.we = 1; end
            6'h03: begin e.addr = w[25:18]; e.s2 = w[4:0]; e.mw = 1; u2 = 1; end
            default:
                if (o <= 6'h10) begin
                    e.alu = o[3:0] - 4'd4;
                    e.rd2 = w[25:21];
                    e.rd = w[20:16];
                    e.s2 = w[9:5];
                    e.s1 = w[4:0];
                    e.we = 1;
                    u1 = 1;
                    u2 = !(o == 6'h06 || o == 6'h0E);
                end else
                    e.ill = 1;
        endcase
        e.hz = pwe && ((u1 && e.s1 == prd) || (u2 && e.s2 == prd));
        return e;
    endfunction

    function automatic logic [31:0] alu(input logic [5:0] o, input logic [4:0] d2, d, b, a);
        return {o, d2, d, 6'b0, b, a};
    endfunction
    function automatic logic [31:0] ldi(input logic [4:0] d, input logic [15:0] imm);
        return {6'h00, d, 5'b0, imm};
    endfunction
    function automatic logic [31:0] mov(input logic [4:0] d, input logic [4:0] s);
        return {6'h01, d, 16'b0, s};
    endfunction
    function automatic logic [31:0] ld(input logic [4:0] d, input logic [7:0] a);
        return {6'h02, d, 13'b0, a};
    endfunction
    function automatic logic [31:0] st(input logic [7:0] a, input logic [4:0] s);
        return {6'h03, a, 13'b0, s};
    endfunction

    // Scoreboard: push on input transfer (program-order hazard model), pop on output transfer.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            q.delete();
            cpwe = 0;
            cprd = 0;
            ex_issued = 0;
            ex_illegal = 0;
            ex_hazard = 0;
        end else begin
            if (out_valid && out_ready) begin
                chk("out_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    ce = q.pop_front();
                    chk("uop", 64'(act), 64'(ce));
                    ex_issued++;
                    ex_illegal += int'(ce.ill);
                    ex_hazard += int'(ce.hz);
                end
            end
            if (in_valid && in_ready) begin
                ce = model(in_instr, cpwe, cprd);
                q.push_back(ce);
                cpwe = ce.we;
                cprd = ce.rd;
            end
        end
    end

    task automatic send(input logic [31:0] w);
        logic ok;
        int n;
        ok = 0;
        n = 0;
        in_valid = 1;
        in_instr = w;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 0;
        chk("send_accept", 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        in_valid = 0;
        in_instr = 0;
        out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_alu_op", 64'(out_alu_op), 64'd15);
        chk("rst_fields", 64'({out_opc, out_rdst, out_rdst2, out_rsrc1, out_rsrc2, out_imm,
                               out_addr, out_we, out_mem_rd, out_mem_wr, out_illegal, out_raw_hazard}), 64'd0);
`ifdef DECODE_STATS_EN
        chk("rst_stats", 64'({stat_issued, stat_illegal, stat_hazard}), 64'd0);
`endif
        rst = 0;

        send(32'h1022_1443);
        chk("latency_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        out_ready = 0;
        send(ldi(5'd7, 16'hBEEF));
        send(mov(5'd8, 5'd7));
        chk("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1;
        in_instr = st(8'h5A, 5'd8);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_hold", 64'(act), 64'(q[0]));
        out_ready = 1;
        send(st(8'h5A, 5'd8));

        send(alu(6'h04, 5'd1, 5'd3, 5'd9, 5'd10));
        send(alu(6'h09, 5'd0, 5'd4, 5'd11, 5'd3));
        send(alu(6'h04, 5'd0, 5'd3, 5'd1, 5'd2));
        send(ldi(5'd3, 16'h1234));
        send(ld(5'd5, 8'h33));
        send(st(8'h44, 5'd5));
        send(mov(5'd9, 5'd0));
        send(ldi(5'd0, 16'h0001));
        send(mov(5'd10, 5'd0));
        send(alu(6'h04, 5'd0, 5'd6, 5'd0, 5'd0));
        send(alu(6'h06, 5'd0, 5'd7, 5'd6, 5'd1));
        send(alu(6'h05, 5'd0, 5'd12, 5'd7, 5'd2));
        send(alu(6'h0E, 5'd0, 5'd13, 5'd12, 5'd4));
        send(alu(6'h10, 5'd2, 5'd14, 5'd13, 5'd13));
        send(32'hFC00_0000 | 32'h0021_0003);
        send(alu(6'h11, 5'd0, 5'd0, 5'd0, 5'd0));
        send(alu(6'h08, 5'd3, 5'd15, 5'd5, 5'd6));
        for (int i = 0; i < 24; i++)
            send({6'($urandom_range(0, 18)), 26'($urandom)});
        repeat (2) @(posedge clk);
        #1;

        out_ready = 0;
        send(ldi(5'd1, 16'h1111));
        send(ldi(5'd2, 16'h2222));
        rst = 1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        rst = 0;
        out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_stale", 64'(out_valid), 64'd0);
        send(mov(5'd4, 5'd2));
        send(alu(6'h3F, 5'd1, 5'd1, 5'd1, 5'd1));
        send(mov(5'd6, 5'd4));

        for (int i = 0; i < 20 && q.size() != 0; i++)
            @(posedge clk);
        @(posedge clk);
        #1;
        chk("drained", 64'(q.size()), 64'd0);
`ifdef DECODE_STATS_EN
        chk("stat_issued", 64'(stat_issued), 64'(ex_issued));
        chk("stat_illegal", 64'(stat_illegal), 64'(ex_illegal));
        chk("stat_hazard", 64'(stat_hazard), 64'(ex_hazard));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
